cdc_hs_tx: RTL and testbench

Source-domain transmitter of the four-phase req/ack CDC handshake. It captures a bus word from a local producer, drives it with a level request towards a destination clock domain, and synchronizes the returning acknowledge internally through a multi-flop chain. It releases the producer only after the full req-high/ack-high/req-low/ack-low cycle. It is the sending end paired with the destination-side bit synchronizer and receiver that sample `tx_req`/`tx_data`.

---
 rtl/cdc_hs_tx.sv | 127 ++++++++++++
 tb/tb_cdc_hs_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: source-domain transmitter of a four-phase req/ack CDC handshake.
//
// Captures a word from a local producer (valid/ready), presents it on tx_data
// with a level request tx_req, and waits for the destination's acknowledge to
// go high and then low again before accepting the next word. The acknowledge
// is synchronised through a NUM_STAGES flop chain; only the synchronised copy
// is used by the control logic.
//
// Ports:
//   CLK        in   source-domain clock (rising edge)
//   rst        in   asynchronous active-high reset
//   src_data   in   BUS_WIDTH word from producer, captured on acceptance
//   src_valid  in   producer has a word
//   src_ready  out  registered, block can accept a word
//   tx_req     out  registered level request to destination
//   tx_data    out  registered word, stable while a transfer is in flight
//   tx_ack     in   asynchronous acknowledge from destination
//   done       out  registered one-cycle pulse on handshake completion
module cdc_hs_tx #(
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] src_data,
  input  logic                 src_valid,
  output logic                 src_ready,
  output logic                 tx_req,
  output logic [BUS_WIDTH-1:0] tx_data,
  input  logic                 tx_ack,
  output logic                 done
);

  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("cdc_hs_tx: NUM_STAGES must be at least 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitLow
  } state_e;

  state_e                 r_state;
  state_e                 w_state_d;
  logic [NUM_STAGES-1:0]  r_ack_sync;
  logic                   w_ack_s;
  logic                   r_src_ready;
  logic                   w_src_ready_d;
  logic                   r_tx_req;
  logic                   w_tx_req_d;
  logic [BUS_WIDTH-1:0]   r_tx_data;
  logic [BUS_WIDTH-1:0]   w_tx_data_d;
  logic                   r_done;
  logic                   w_done_d;

  // Acknowledge synchroniser: tx_ack enters at bit 0, ack_s is the last stage.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[NUM_STAGES-2:0], tx_ack};
    end
  end

  assign w_ack_s = r_ack_sync[NUM_STAGES-1];

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_src_ready <= 1'b0;
      r_tx_req    <= 1'b0;
      r_tx_data   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_src_ready <= w_src_ready_d;
      r_tx_req    <= w_tx_req_d;
      r_tx_data   <= w_tx_data_d;
      r_done      <= w_done_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_src_ready_d = r_src_ready;
    w_tx_req_d    = r_tx_req;
    w_tx_data_d   = r_tx_data;
    w_done_d      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (src_valid && r_src_ready) begin
          w_tx_data_d   = src_data;
          w_tx_req_d    = 1'b1;
          w_src_ready_d = 1'b0;
          w_state_d     = StReq;
        end else begin
          // Also raises ready on the first edge after reset release.
          w_src_ready_d = 1'b1;
        end
      end
      StReq: begin
        if (w_ack_s) begin
          w_tx_req_d = 1'b0;
          w_state_d  = StWaitLow;
        end
      end
      StWaitLow: begin
        // Release the producer only once ack has returned to zero.
        if (!w_ack_s) begin
          w_src_ready_d = 1'b1;
          w_done_d      = 1'b1;
          w_state_d     = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign src_ready = r_src_ready;
  assign tx_req    = r_tx_req;
  assign tx_data   = r_tx_data;
  assign done      = r_done;

endmodule

// File: tb/tb_cdc_hs_tx.sv
module tb_cdc_hs_tx;

  localparam int W = 8;
  localparam int N = 2;

  logic         CLK = 1'b0;
  logic         rst;
  logic [W-1:0] src_data;
  logic         src_valid;
  logic         src_ready;
  logic         tx_req;
  logic [W-1:0] tx_data;
  logic         done;
  logic         w_ack;

  // Destination behaviour: 0 = ack driven by hand, 1 = loopback, 2 = delayed responder.
  int   ack_mode = 0;
  logic r_ack = 1'b0;
  int   dly_fix = 10;
  bit   dly_rand = 0;
  int   cur_dly = 10;
  int   dcnt = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  assign w_ack = (ack_mode == 1) ? tx_req : r_ack;

  cdc_hs_tx #(
    .BUS_WIDTH (W),
    .NUM_STAGES(N)
  ) dut (
    .CLK      (CLK),
    .rst      (rst),
    .src_data (src_data),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .tx_ack   (w_ack),
    .done     (done)
  );

  initial forever #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial forever begin
    @(negedge CLK);
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit         m_busy;
  bit         m_req;
  bit         m_ready;
  bit         m_done;
  bit [W-1:0] m_data;
  bit         m_q[$];   // ack samples still travelling through the synchroniser

  task automatic m_reset();
    m_busy  = 0;
    m_req   = 0;
    m_ready = 0;
    m_done  = 0;
    m_data  = '0;
    m_q.delete();
    for (int i = 0; i < N; i++) m_q.push_back(1'b0);
  endtask

  task automatic m_step();
    bit ack_in;
    bit ack_seen;
    ack_in   = (ack_mode == 1) ? m_req : (r_ack === 1'b1);
    ack_seen = m_q.pop_front();  // ack as it was N edges ago
    m_q.push_back(ack_in);
    m_done = 0;
    if (!m_busy) begin
      if ((src_valid === 1'b1) && m_ready) begin
        m_data  = src_data;
        m_req   = 1;
        m_ready = 0;
        m_busy  = 1;
      end else begin
        m_ready = 1;
      end
    end else if (m_req) begin
      if (ack_seen) m_req = 0;
    end else if (!ack_seen) begin
      m_busy  = 0;
      m_ready = 1;
      m_done  = 1;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge CLK or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  // Compare process: outputs checked against the model on every falling edge.
  initial forever begin
    @(negedge CLK);
    chk("cmp_src_ready", 32'(src_ready), 32'(m_ready));
    chk("cmp_tx_req",    32'(tx_req),    32'(m_req));
    chk("cmp_tx_data",   32'(tx_data),   32'(m_data));
    chk("cmp_done",      32'(done),      32'(m_done));
  end

  // Delayed destination: follows tx_req after cur_dly falling edges.
  initial forever begin
    @(negedge CLK);
    if (rst) begin
      dcnt = 0;
    end else if (ack_mode == 2) begin
      if (tx_req !== r_ack) begin
        if (dcnt >= cur_dly) begin
          r_ack   = tx_req;
          dcnt    = 0;
          cur_dly = dly_rand ? int'($urandom_range(0, 12)) : dly_fix;
        end else begin
          dcnt++;
        end
      end else begin
        dcnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Called on a falling edge; returns on the first falling edge with src_ready high.
  task automatic wait_ready(input int max_cyc);
    int n;
    n = 0;
    while (src_ready !== 1'b1 && n < max_cyc) begin
      @(negedge CLK);
      n++;
    end
    chk("wait_ready", 32'(src_ready), 32'd1);
  endtask

  int t0;
  int acc [1:3];
  int req_hi;
  int dsnap;
  int n;

  initial begin
    rst       = 1'b1;
    src_valid = 1'b0;
    src_data  = '0;

    // Reset with a toggling ack.
    repeat (3) begin
      @(negedge CLK);
      r_ack = ~r_ack;
      chk("rst_src_ready", 32'(src_ready), 32'd0);
      chk("rst_tx_req", 32'(tx_req), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end
    r_ack = 1'b0;
    rst   = 1'b0;
    @(negedge CLK);
    chk("rel_src_ready", 32'(src_ready), 32'd1);
    chk("rel_tx_req", 32'(tx_req), 32'd0);

    // Single loopback transfer of A5.
    ack_mode  = 1;
    src_data  = 8'hA5;
    src_valid = 1'b1;
    @(negedge CLK);
    src_valid = 1'b0;
    chk("single_e0_req", 32'(tx_req), 32'd1);
    chk("single_e0_data", 32'(tx_data), 32'hA5);
    repeat (2) @(negedge CLK);
    chk("single_e2_req", 32'(tx_req), 32'd1);
    @(negedge CLK);
    chk("single_e3_req", 32'(tx_req), 32'd0);
    repeat (2) @(negedge CLK);
    chk("single_e5_ready", 32'(src_ready), 32'd0);
    @(negedge CLK);
    chk("single_e6_ready", 32'(src_ready), 32'd1);
    chk("single_e6_done", 32'(done), 32'd1);
    @(negedge CLK);
    chk("single_e7_done", 32'(done), 32'd0);

    // Back-to-back words with src_valid held high.
    dsnap     = done_cnt;
    src_valid = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      src_data = 8'(w);
      wait_ready(20);
      @(negedge CLK);
      acc[w] = cyc;
      chk("b2b_data", 32'(tx_data), 32'(w));
    end
    src_valid = 1'b0;
    chk("b2b_gap12", 32'(acc[2] - acc[1]), 32'd7);
    chk("b2b_gap23", 32'(acc[3] - acc[2]), 32'd7);
    wait_ready(20);
    @(negedge CLK);
    chk("b2b_done_pulses", 32'(done_cnt - dsnap), 32'd3);

    // Slow destination: ack follows req after 10 falling edges each way.
    ack_mode  = 2;
    dly_rand  = 0;
    dly_fix   = 10;
    cur_dly   = 10;
    src_data  = 8'hC3;
    src_valid = 1'b1;
    @(negedge CLK);
    src_valid = 1'b0;
    t0        = cyc;
    req_hi    = 0;
    n         = 0;
    while (done !== 1'b1 && n < 60) begin
      if (tx_req === 1'b1) req_hi++;
      chk("slow_data_stable", 32'(tx_data), 32'hC3);
      chk("slow_ready_low", 32'(src_ready), 32'd0);
      @(negedge CLK);
      n++;
    end
    chk("slow_done", 32'(done), 32'd1);
    chk("slow_req_high_cycles", 32'(req_hi), 32'd13);
    chk("slow_done_latency", 32'(cyc - t0), 32'd26);

    // Spurious ack while idle.
    ack_mode = 0;
    @(negedge CLK);
    r_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) r_ack = 1'b0;
      @(negedge CLK);
      chk("spur_ready", 32'(src_ready), 32'd1);
      chk("spur_req", 32'(tx_req), 32'd0);
      chk("spur_done", 32'(done), 32'd0);
      chk("spur_data", 32'(tx_data), 32'hC3);
    end

    // Reset in the middle of a transfer, then recover.
    src_data  = 8'h3C;
    src_valid = 1'b1;
    @(negedge CLK);
    src_valid = 1'b0;
    repeat (2) @(negedge CLK);
    chk("mid_req_before", 32'(tx_req), 32'd1);
    chk("mid_data_before", 32'(tx_data), 32'h3C);
    #1 rst = 1'b1;
    #1;
    chk("mid_async_req", 32'(tx_req), 32'd0);
    chk("mid_async_data", 32'(tx_data), 32'd0);
    chk("mid_async_ready", 32'(src_ready), 32'd0);
    chk("mid_async_done", 32'(done), 32'd0);
    repeat (2) @(negedge CLK);
    rst      = 1'b0;
    ack_mode = 1;
    @(negedge CLK);
    wait_ready(5);
    src_data  = 8'h77;
    src_valid = 1'b1;
    @(negedge CLK);
    src_valid = 1'b0;
    chk("recov_data", 32'(tx_data), 32'h77);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("recov_done", 32'(done), 32'd1);

    // Randomised traffic against a destination with random delays.
    ack_mode = 2;
    dly_rand = 1;
    cur_dly  = 3;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      src_valid = 1'($urandom_range(0, 1));
      src_data  = W'($urandom);
    end
    src_valid = 1'b0;
    @(negedge CLK);
    wait_ready(80);
    repeat (2) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
